// File: rtl/config_table_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_table_loader_pkg
// Shared constants, FSM state type and a small helper for the configuration
// table loader.
//   phit_size    : AXIS tdata width and table write-data width
//   dwidth_RFadd : table entry address width
//   depth_RF     : number of table entries (2**dwidth_RFadd)
//   HDR_*        : header beat field positions
// -----------------------------------------------------------------------------
package config_table_loader_pkg;

  localparam int phit_size    = 512;
  localparam int dwidth_RFadd = 4;
  localparam int depth_RF     = 1 << dwidth_RFadd;

  localparam int HDR_BASE_LSB = 0;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_CNT_W    = 16;

  // 2*65535 beats fit in 17 bits, so the beat index never wraps.
  localparam int BEAT_CNT_W   = HDR_CNT_W + 1;
  localparam int ENTRIES_W    = dwidth_RFadd + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} cfg_ld_state_t;

  // Distinct table entries touched by an N-entry packet. When N exceeds the
  // table depth the addresses wrap, so at most depth_RF entries hold data.
  function automatic logic [ENTRIES_W-1:0] entries_written(input logic [HDR_CNT_W-1:0] n);
    if (n > HDR_CNT_W'(depth_RF)) begin
      return ENTRIES_W'(depth_RF);
    end
    return n[ENTRIES_W-1:0];
  endfunction

endpackage

// File: rtl/config_table_loader_if.sv
// -----------------------------------------------------------------------------
// config_table_loader_if
// AXI-Stream (H2C) beat interface feeding the configuration table loader.
//   tdata  : stream data, phit_size bits
//   tvalid : stream valid
//   tlast  : last beat of packet
//   tready : stream ready (driven by the loader)
// modport master : upstream source (QDMA side)
// modport slave  : loader side
// -----------------------------------------------------------------------------
interface config_table_loader_if;
  import config_table_loader_pkg::*;

  logic [phit_size-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/config_table_loader.sv
// -----------------------------------------------------------------------------
// config_table_loader
// Parses a one-beat header (base entry, entry count N) followed by 2 beats per
// table entry (control phit, then immediate phit) and drives the table write
// port. Malformed packets pulse err; clean packets pulse done.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_axis         : stream input (slave modport)
//   lock           : high -> no new packet may start
//   wr_en/wr_add/wr_half/wr_data : registered table write port
//   busy           : packet in progress
//   done, err      : 1-cycle completion pulses, aligned with the last write
//   entries_loaded : entries written by the last clean packet
// -----------------------------------------------------------------------------
module config_table_loader
  import config_table_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  config_table_loader_if.slave    s_axis,
  input  logic                    lock,
  output logic                    wr_en,
  output logic [dwidth_RFadd-1:0] wr_add,
  output logic                    wr_half,
  output logic [phit_size-1:0]    wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ENTRIES_W-1:0]    entries_loaded
);

  cfg_ld_state_t           state_reg, state_next;
  logic [BEAT_CNT_W-1:0]   k_reg, k_next;
  logic [dwidth_RFadd-1:0] base_reg, base_next;
  logic [HDR_CNT_W-1:0]    n_reg, n_next;

  logic                    wr_en_next, wr_half_next, done_next, err_next;
  logic [dwidth_RFadd-1:0] wr_add_next;
  logic [phit_size-1:0]    wr_data_next;
  logic [ENTRIES_W-1:0]    entries_next;

  logic                    accept;
  logic [dwidth_RFadd-1:0] hdr_base;
  logic [HDR_CNT_W-1:0]    hdr_cnt;
  logic [BEAT_CNT_W-1:0]   last_k;

  // Only the header can be held off; payload beats are always taken.
  // Gated by rst_n so that every output reads 0 while in reset.
  assign s_axis.tready = rst_n && ((state_reg != IDLE) || !lock);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign busy          = (state_reg != IDLE);

  assign hdr_base = s_axis.tdata[HDR_BASE_LSB +: dwidth_RFadd];
  assign hdr_cnt  = s_axis.tdata[HDR_CNT_LSB +: HDR_CNT_W];
  assign last_k   = {n_reg, 1'b0} - BEAT_CNT_W'(1);

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    base_next    = base_reg;
    n_next       = n_reg;
    wr_en_next   = 1'b0;
    wr_add_next  = wr_add;
    wr_half_next = wr_half;
    wr_data_next = wr_data;
    done_next    = 1'b0;
    err_next     = 1'b0;
    entries_next = entries_loaded;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          if (hdr_cnt == '0) begin
            if (s_axis.tlast) begin
              done_next    = 1'b1;
              entries_next = '0;
            end else begin
              // Empty header with trailing beats: flag it and swallow the rest.
              err_next   = 1'b1;
              state_next = DRAIN;
            end
          end else if (s_axis.tlast) begin
            err_next = 1'b1;
          end else begin
            state_next = LOAD;
            base_next  = hdr_base;
            n_next     = hdr_cnt;
            k_next     = '0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en_next   = 1'b1;
          // k/2 selects the entry, k[0] the half; the sum wraps at depth_RF.
          wr_add_next  = base_reg + k_reg[dwidth_RFadd:1];
          wr_half_next = k_reg[0];
          wr_data_next = s_axis.tdata;
          k_next       = k_reg + BEAT_CNT_W'(1);
          if (k_reg == last_k) begin
            if (s_axis.tlast) begin
              done_next    = 1'b1;
              entries_next = entries_written(n_reg);
              state_next   = IDLE;
            end else begin
              err_next   = 1'b1;
              state_next = DRAIN;
            end
          end else if (s_axis.tlast) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (accept && s_axis.tlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      base_reg       <= '0;
      n_reg          <= '0;
      wr_en          <= 1'b0;
      wr_add         <= '0;
      wr_half        <= 1'b0;
      wr_data        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      entries_loaded <= '0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      base_reg       <= base_next;
      n_reg          <= n_next;
      wr_en          <= wr_en_next;
      wr_add         <= wr_add_next;
      wr_half        <= wr_half_next;
      wr_data        <= wr_data_next;
      done           <= done_next;
      err            <= err_next;
      entries_loaded <= entries_next;
    end
  end

endmodule

// File: tb/tb_config_table_loader.sv
// -----------------------------------------------------------------------------
// tb_config_table_loader
// Directed packets; expected table writes and pulses are derived per packet
// from the packet rules and checked by one compare process every cycle.
// -----------------------------------------------------------------------------
module tb_config_table_loader;
  import config_table_loader_pkg::*;

  typedef struct {
    bit           we;
    logic [3:0]   add;
    bit           half;
    logic [511:0] data;
    bit           done;
    bit           err;
    bit           ent_valid;
    logic [4:0]   ent;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lock = 1'b0;
  logic         wr_en, wr_half, busy, done, err;
  logic [3:0]   wr_add;
  logic [511:0] wr_data;
  logic [4:0]   entries_loaded;

  config_table_loader_if s_axis ();

  config_table_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis         (s_axis.slave),
    .lock           (lock),
    .wr_en          (wr_en),
    .wr_add         (wr_add),
    .wr_half        (wr_half),
    .wr_data        (wr_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .entries_loaded (entries_loaded)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[int];
  logic [4:0] cur_ent = '0;
  logic [4:0] obs[$];
  int   done_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t r;
    r.we = 0; r.add = '0; r.half = 0; r.data = '0;
    r.done = 0; r.err = 0; r.ent_valid = 0; r.ent = '0;
    return r;
  endfunction

  function automatic logic [511:0] mk_data(input int seed, input int k);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(seed * 65536 + k * 256 + i);
    return d;
  endfunction

  // Compare process: one check set per cycle, sampled at the falling edge.
  always @(negedge clk) begin
    exp_t r;
    if (rst_n) begin
      if (exp_q.exists(edges)) begin
        r = exp_q[edges];
        exp_q.delete(edges);
      end else begin
        r = blank();
      end
      if (r.ent_valid) cur_ent = r.ent;
      chk("wr_en", 512'(wr_en), 512'(r.we));
      if (r.we) begin
        chk("wr_add", 512'(wr_add), 512'(r.add));
        chk("wr_half", 512'(wr_half), 512'(r.half));
        chk("wr_data", wr_data, r.data);
      end
      chk("done", 512'(done), 512'(r.done));
      chk("err", 512'(err), 512'(r.err));
      chk("entries_loaded", 512'(entries_loaded), 512'(cur_ent));
      if (wr_en) obs.push_back({wr_add, wr_half});
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  // Present one beat, expect it accepted at the next rising edge, and file
  // the outputs that must appear one cycle after that edge.
  task automatic drive(input logic [511:0] d, input bit last, input bit exp_busy, input exp_t r);
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = last;
    #1;
    chk("tready", 512'(s_axis.tready), 512'(1));
    chk("busy", 512'(busy), 512'(exp_busy));
    exp_q[edges + 1] = r;
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // last_at: -1 = tlast on the header, -2 = no tlast, else payload beat index.
  // lock_at: payload beat before which lock is raised (-1 = never).
  task automatic send_pkt(input int base, input int n, input int nbeats,
                          input int last_at, input int lock_at, input int seed);
    logic [511:0] hdr, d;
    exp_t r;
    bit   in_load;
    hdr = '0;
    hdr[3:0]     = 4'(base);
    hdr[31:16]   = 16'(n);
    hdr[511:448] = 64'hDEAD_BEEF_0BAD_F00D;
    r = blank();
    in_load = 0;
    if (last_at == -1) begin
      if (n == 0) begin
        r.done = 1; r.ent_valid = 1; r.ent = '0;
      end else begin
        r.err = 1;
      end
    end else if (n == 0) begin
      r.err = 1;
    end else begin
      in_load = 1;
    end
    drive(hdr, last_at == -1, 0, r);
    for (int k = 0; k < nbeats; k++) begin
      d = mk_data(seed, k);
      r = blank();
      if (in_load && k < 2 * n) begin
        r.we = 1;
        r.add = 4'((base + k / 2) % 16);
        r.half = 1'(k % 2);
        r.data = d;
        if (k == 2 * n - 1) begin
          if (k == last_at) begin
            r.done = 1; r.ent_valid = 1; r.ent = (n > 16) ? 5'd16 : 5'(n);
          end else begin
            r.err = 1;
          end
          in_load = 0;
        end else if (k == last_at) begin
          r.err = 1;
          in_load = 0;
        end
      end
      if (k == lock_at) lock = 1'b1;
      drive(d, k == last_at, 1, r);
    end
    lock = 1'b0;
    $display("pkt base=%0d n=%0d beats=%0d tlast_at=%0d lock_at=%0d", base, n, nbeats, last_at, lock_at);
  endtask

  task automatic clear_obs();
    obs.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] hold_hdr;
    s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", 512'(wr_en), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_entries", 512'(entries_loaded), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: base 3, N=2
    clear_obs();
    send_pkt(3, 2, 4, 3, -1, 1);
    @(negedge clk);
    chk("t1_nwr", 512'(obs.size()), 512'(4));
    chk("t1_w0", 512'(obs[0]), 512'({4'd3, 1'b0}));
    chk("t1_w1", 512'(obs[1]), 512'({4'd3, 1'b1}));
    chk("t1_w2", 512'(obs[2]), 512'({4'd4, 1'b0}));
    chk("t1_w3", 512'(obs[3]), 512'({4'd4, 1'b1}));
    chk("t1_entries", 512'(entries_loaded), 512'(2));

    // 2: base 15 wraps to 0
    clear_obs();
    send_pkt(15, 2, 4, 3, -1, 2);
    @(negedge clk);
    chk("t2_a0", 512'(obs[0][4:1]), 512'(15));
    chk("t2_a1", 512'(obs[1][4:1]), 512'(15));
    chk("t2_a2", 512'(obs[2][4:1]), 512'(0));
    chk("t2_a3", 512'(obs[3][4:1]), 512'(0));
    chk("t2_errs", 512'(err_cnt), 512'(0));

    // 3: early tlast, then next header back-to-back
    clear_obs();
    send_pkt(6, 3, 3, 2, -1, 3);
    send_pkt(0, 1, 2, 1, -1, 4);
    @(negedge clk);
    chk("t3_nwr", 512'(obs.size()), 512'(5));
    chk("t3_errs", 512'(err_cnt), 512'(1));
    chk("t3_dones", 512'(done_cnt), 512'(1));

    // 4: missing tlast, extra beats drained
    clear_obs();
    send_pkt(9, 1, 5, 4, -1, 5);
    @(negedge clk);
    chk("t4_nwr", 512'(obs.size()), 512'(2));
    chk("t4_errs", 512'(err_cnt), 512'(1));
    chk("t4_busy", 512'(busy), 512'(0));

    // Header-only cases
    clear_obs();
    send_pkt(7, 0, 0, -1, -1, 6);
    send_pkt(7, 0, 3, 2, -1, 7);
    send_pkt(2, 3, 0, -1, -1, 8);
    @(negedge clk);
    chk("hdr_nwr", 512'(obs.size()), 512'(0));
    chk("hdr_entries", 512'(entries_loaded), 512'(0));
    chk("hdr_errs", 512'(err_cnt), 512'(2));

    // N > depth_RF wraps and overwrites
    clear_obs();
    send_pkt(10, 17, 34, 33, -1, 9);
    @(negedge clk);
    chk("big_nwr", 512'(obs.size()), 512'(34));
    chk("big_last_add", 512'(obs[33][4:1]), 512'(10));
    chk("big_entries", 512'(entries_loaded), 512'(16));

    // 5: lock in IDLE holds the header off, lock mid-LOAD is ignored
    clear_obs();
    hold_hdr = '0;
    hold_hdr[3:0] = 4'd5;
    hold_hdr[31:16] = 16'd1;
    lock = 1'b1;
    s_axis.tdata = hold_hdr; s_axis.tvalid = 1'b1; s_axis.tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_tready", 512'(s_axis.tready), 512'(0));
      @(negedge clk);
    end
    chk("lock_nwr", 512'(obs.size()), 512'(0));
    lock = 1'b0;
    send_pkt(5, 1, 2, 1, -1, 10);
    send_pkt(8, 2, 4, 3, 1, 11);
    @(negedge clk);
    chk("t5_dones", 512'(done_cnt), 512'(2));
    chk("t5_entries", 512'(entries_loaded), 512'(2));

    // 6: async reset mid-packet
    send_pkt(0, 2, 2, -2, -1, 12);
    @(negedge clk);
    chk("t6_busy_pre", 512'(busy), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wr_en", 512'(wr_en), 512'(0));
    chk("t6_wr_add", 512'(wr_add), 512'(0));
    chk("t6_wr_data", wr_data, 512'(0));
    chk("t6_busy", 512'(busy), 512'(0));
    chk("t6_entries", 512'(entries_loaded), 512'(0));
    chk("t6_tready", 512'(s_axis.tready), 512'(0));
    @(negedge clk); @(negedge clk);
    exp_q.delete();
    cur_ent = '0;
    rst_n = 1'b1;
    clear_obs();
    send_pkt(0, 1, 2, 1, -1, 13);
    @(negedge clk);
    chk("t6_post_w0", 512'(obs[0]), 512'({4'd0, 1'b0}));
    chk("t6_post_w1", 512'(obs[1]), 512'({4'd0, 1'b1}));
    chk("t6_post_entries", 512'(entries_loaded), 512'(1));

    @(negedge clk); @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
